// File: rtl/ft_rx_deframer.sv
// Deframer for the FT60x bridge RX FIFO: hunts SYNC, parses LEN + payload + additive CSUM,
// streams payload on valid/ready and keeps saturating good/error frame counters.
module ft_rx_deframer #(
    parameter int          BUS_WIDTH = 16,
    parameter int          MAX_LEN   = 1024,
    parameter logic [15:0] SYNC_WORD = 16'hA55A,
    parameter int          TIMEOUT   = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [BUS_WIDTH-1:0]   ui_dout,
    input  logic [BUS_WIDTH/8-1:0] ui_dout_be,
    input  logic                   ui_dout_empty,
    output logic                   ui_dout_get,
    output logic [BUS_WIDTH-1:0]   m_data,
    output logic [BUS_WIDTH/8-1:0] m_be,
    output logic                   m_last,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   frame_done,
    output logic                   err_csum,
    output logic                   err_len,
    output logic                   err_timeout,
    output logic [15:0]            cnt_ok,
    output logic [15:0]            cnt_err,
    output logic [1:0]             state
);

    localparam int BW = BUS_WIDTH / 8;
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [BUS_WIDTH-1:0] SYNC    = BUS_WIDTH'(SYNC_WORD);
    localparam logic [BUS_WIDTH-1:0] LEN_MAX = BUS_WIDTH'(MAX_LEN);
    // Registered pulse lands exactly TIMEOUT cycles after the last pop cycle.
    localparam logic [TW-1:0]        TMO_LAST = TW'(TIMEOUT - 2);

    typedef enum logic [1:0] {HUNT = 2'd0, LEN = 2'd1, PAYLOAD = 2'd2, CSUM = 2'd3} state_t;

    state_t                 state_q, state_n;
    logic [15:0]            remaining;
    logic [BUS_WIDTH-1:0]   sum;
    logic [TW-1:0]          tmo_cnt;
    logic                   be_full;
    logic                   done_n, csum_err_n, len_err_n, tmo_n, any_err_n;

    assign be_full   = &ui_dout_be;
    assign any_err_n = csum_err_n | len_err_n | tmo_n;
    assign state     = state_q;

    // m_valid/m_ready: a word transfers on a cycle where both are high; while m_valid
    // is high and m_ready low, m_data/m_be/m_last hold and no payload word is popped.
    always_comb begin
        ui_dout_get = 1'b0;
        state_n     = state_q;
        done_n      = 1'b0;
        csum_err_n  = 1'b0;
        len_err_n   = 1'b0;
        tmo_n       = 1'b0;
        if (rst_n) begin
            if (state_q == PAYLOAD) ui_dout_get = !ui_dout_empty && (!m_valid || m_ready);
            else                    ui_dout_get = !ui_dout_empty;
        end
        case (state_q)
            HUNT: if (ui_dout_get && ui_dout == SYNC && be_full) state_n = LEN;
            LEN: if (ui_dout_get) begin
                if (!be_full || ui_dout == '0 || ui_dout > LEN_MAX) begin
                    len_err_n = 1'b1;
                    state_n   = HUNT;
                end else begin
                    state_n = PAYLOAD;
                end
            end
            PAYLOAD: if (ui_dout_get && remaining == 16'd1) state_n = CSUM;
            CSUM: if (ui_dout_get) begin
                done_n     = 1'b1;
                csum_err_n = (ui_dout != sum);
                state_n    = HUNT;
            end
            default: state_n = HUNT;
        endcase
        if (state_q != HUNT && !ui_dout_get && tmo_cnt == TMO_LAST) begin
            tmo_n   = 1'b1;
            state_n = HUNT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            remaining   <= '0;
            sum         <= '0;
            tmo_cnt     <= '0;
            frame_done  <= 1'b0;
            err_csum    <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            cnt_ok      <= '0;
            cnt_err     <= '0;
        end else begin
            state_q     <= state_n;
            frame_done  <= done_n;
            err_csum    <= csum_err_n;
            err_len     <= len_err_n;
            err_timeout <= tmo_n;
            if (ui_dout_get || state_q == HUNT || tmo_n) tmo_cnt <= '0;
            else                                          tmo_cnt <= tmo_cnt + TW'(1);
            if (state_q == LEN && state_n == PAYLOAD) begin
                remaining <= ui_dout[15:0];
                sum       <= '0;
            end else if (state_q == PAYLOAD && ui_dout_get) begin
                remaining <= remaining - 16'd1;
                sum       <= sum + ui_dout;
            end
            if (done_n && !csum_err_n && cnt_ok != 16'hFFFF) cnt_ok <= cnt_ok + 16'd1;
            if (any_err_n && cnt_err != 16'hFFFF)              cnt_err <= cnt_err + 16'd1;
        end
    end

    // Output register drains on its own, independent of the parser state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_data  <= '0;
            m_be    <= '0;
        end else if (state_q == PAYLOAD && ui_dout_get) begin
            m_valid <= 1'b1;
            m_last  <= (remaining == 16'd1);
            m_data  <= ui_dout;
            m_be    <= ui_dout_be;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ft_rx_deframer.sv
// Bench for ft_rx_deframer: FIFO source model, directed frames, scoreboard monitor
// comparing payload words and status pulses against hand-computed expectations.
module tb_ft_rx_deframer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] ui_dout;
    logic [1:0]  ui_dout_be;
    logic        ui_dout_empty;
    logic        ui_dout_get;
    logic [15:0] m_data;
    logic [1:0]  m_be;
    logic        m_last, m_valid;
    logic        m_ready = 1'b1;
    logic        frame_done, err_csum, err_len, err_timeout;
    logic [15:0] cnt_ok, cnt_err;
    logic [1:0]  dbg_state;

    logic [17:0] src_q[$];
    logic [18:0] exp_q[$];
    logic [3:0]  ev_q[$];
    int          hs_cyc_q[$];
    int          n_checks = 0, n_fail = 0;
    int          cyc = 0, hs_count = 0, ev_seen = 0;
    int          last_pop_cyc = 0, tmo_cyc = 0;
    logic        pend = 1'b0;

    ft_rx_deframer #(.BUS_WIDTH(16), .MAX_LEN(1024), .SYNC_WORD(16'hA55A), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .ui_dout(ui_dout), .ui_dout_be(ui_dout_be), .ui_dout_empty(ui_dout_empty),
        .ui_dout_get(ui_dout_get),
        .m_data(m_data), .m_be(m_be), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
        .frame_done(frame_done), .err_csum(err_csum), .err_len(err_len), .err_timeout(err_timeout),
        .cnt_ok(cnt_ok), .cnt_err(cnt_err), .state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic push(input logic [15:0] w, input logic [1:0] be = 2'b11);
        src_q.push_back({be, w});
    endtask

    task automatic expect_word(input logic [15:0] d, input logic last);
        exp_q.push_back({last, 2'b11, d});
    endtask

    task automatic expect_ev(input logic [3:0] e);
        ev_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (n < 3000 && !(src_q.size() == 0 && exp_q.size() == 0 && ev_q.size() == 0 && !m_valid)) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("%s_drained", name), 32'(n < 3000), 32'd1);
        repeat (3) @(negedge clk);
        #3;
    endtask

    // FIFO model: first-word-fall-through head, popped when the DUT strobed get
    initial begin
        ui_dout = '0;
        ui_dout_be = '0;
        ui_dout_empty = 1'b1;
        forever begin
            @(negedge clk);
            if (pend && src_q.size() > 0) void'(src_q.pop_front());
            if (src_q.size() > 0) begin
                ui_dout       = src_q[0][15:0];
                ui_dout_be    = src_q[0][17:16];
                ui_dout_empty = 1'b0;
            end else begin
                ui_dout       = '0;
                ui_dout_be    = '0;
                ui_dout_empty = 1'b1;
            end
            #1;
            pend = ui_dout_get;
            if (ui_dout_get) last_pop_cyc = cyc;
        end
    end

    // scoreboard monitor
    initial begin
        logic [18:0] e;
        logic [3:0]  ev;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (m_valid && m_ready) begin
                    hs_count++;
                    hs_cyc_q.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", {13'd0, m_last, m_be, m_data}, 32'hDEAD);
                    end else begin
                        e = exp_q.pop_front();
                        check("payload", {13'd0, m_last, m_be, m_data}, {13'd0, e});
                    end
                end
                ev = {frame_done, err_csum, err_len, err_timeout};
                if (ev != 4'd0) begin
                    ev_seen++;
                    if (err_timeout) tmo_cyc = cyc;
                    if (ev_q.size() == 0) check("unexpected_status", {28'd0, ev}, 32'd0);
                    else                  check("status", {28'd0, ev}, {28'd0, ev_q.pop_front()});
                end
            end
        end
    end

    initial begin
        int base, n, ev0;

        // reset state, with a word already waiting in the FIFO
        push(16'h1234);
        repeat (3) @(negedge clk);
        #3;
        check("rst_get", 32'(ui_dout_get), 32'd0);
        check("rst_valid", {30'd0, m_valid, m_last}, 32'd0);
        check("rst_data", {14'd0, m_be, m_data}, 32'd0);
        check("rst_pulses", {28'd0, frame_done, err_csum, err_len, err_timeout}, 32'd0);
        check("rst_cnt", {cnt_ok, cnt_err}, 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;

        // basic frame, back-to-back output
        hs_cyc_q.delete();
        push(16'hA55A); push(16'h0003); push(16'h0001); push(16'h0002); push(16'h0003); push(16'h0006);
        expect_word(16'h0001, 1'b0); expect_word(16'h0002, 1'b0); expect_word(16'h0003, 1'b1);
        expect_ev(4'b1000);
        wait_idle("t1");
        check("t1_back_to_back", (hs_cyc_q.size() == 3) ? 32'(hs_cyc_q[2] - hs_cyc_q[0]) : 32'hFFFF_FFFF, 32'd2);
        check("t1_cnt", {cnt_ok, cnt_err}, {16'd1, 16'd0});

        // wrapping checksum: good, then bad
        push(16'hA55A); push(16'h0002); push(16'hFFFF); push(16'h0002); push(16'h0001);
        expect_word(16'hFFFF, 1'b0); expect_word(16'h0002, 1'b1); expect_ev(4'b1000);
        push(16'hA55A); push(16'h0002); push(16'hFFFF); push(16'h0002); push(16'h0002);
        expect_word(16'hFFFF, 1'b0); expect_word(16'h0002, 1'b1); expect_ev(4'b1100);
        wait_idle("t2");
        check("t2_cnt", {cnt_ok, cnt_err}, {16'd2, 16'd1});
        check("t2_state", 32'(dbg_state), 32'd0);

        // junk, including SYNC with partial byte enables
        push(16'hA55A, 2'b01); push(16'h1234); push(16'hA55B);
        push(16'hA55A); push(16'h0001); push(16'h0007); push(16'h0007);
        expect_word(16'h0007, 1'b1); expect_ev(4'b1000);
        wait_idle("t3");
        check("t3_cnt", {cnt_ok, cnt_err}, {16'd3, 16'd1});

        // illegal lengths: zero, MAX_LEN+1, partial be
        push(16'hA55A); push(16'h0000); expect_ev(4'b0010);
        push(16'hA55A); push(16'h0401); expect_ev(4'b0010);
        push(16'hA55A); push(16'h0002, 2'b01); expect_ev(4'b0010);
        push(16'hA55A); push(16'h0001); push(16'h0005); push(16'h0005);
        expect_word(16'h0005, 1'b1); expect_ev(4'b1000);
        wait_idle("t4");
        check("t4_cnt", {cnt_ok, cnt_err}, {16'd4, 16'd4});

        // LEN = MAX_LEN exactly; payload 1..1024 sums to 0x0200 mod 2^16
        push(16'hA55A); push(16'h0400);
        for (int i = 1; i <= 1024; i++) begin
            push(16'(i));
            expect_word(16'(i), i == 1024);
        end
        push(16'h0200); expect_ev(4'b1000);
        wait_idle("t4_maxlen");
        check("t4_maxlen_cnt", {cnt_ok, cnt_err}, {16'd5, 16'd4});

        // backpressure for 5 cycles mid-payload
        base = hs_count;
        push(16'hA55A); push(16'h0004); push(16'h0011); push(16'h0022); push(16'h0033); push(16'h0044);
        push(16'h00AA);
        expect_word(16'h0011, 1'b0); expect_word(16'h0022, 1'b0);
        expect_word(16'h0033, 1'b0); expect_word(16'h0044, 1'b1); expect_ev(4'b1000);
        n = 0;
        while (hs_count < base + 1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #3;
            check("t5_stall_get", 32'(ui_dout_get), 32'd0);
            check("t5_stall_valid", {m_valid, m_data}, {1'b1, 16'h0022});
            @(negedge clk);
        end
        m_ready = 1'b1;
        wait_idle("t5");
        check("t5_cnt", {cnt_ok, cnt_err}, {16'd6, 16'd4});

        // mid-frame timeout after 2 of 4 payload words
        push(16'hA55A); push(16'h0004); push(16'h0001); push(16'h0002);
        expect_word(16'h0001, 1'b0); expect_word(16'h0002, 1'b0); expect_ev(4'b0001);
        wait_idle("t6");
        check("t6_tmo_delay", 32'(tmo_cyc - last_pop_cyc), 32'd16);
        check("t6_state", 32'(dbg_state), 32'd0);
        check("t6_cnt", {cnt_ok, cnt_err}, {16'd6, 16'd5});
        push(16'hA55A); push(16'h0001); push(16'h0009); push(16'h0009);
        expect_word(16'h0009, 1'b1); expect_ev(4'b1000);
        wait_idle("t6_after");
        check("t6_after_cnt", {cnt_ok, cnt_err}, {16'd7, 16'd5});

        // reset mid-payload
        m_ready = 1'b0;
        push(16'hA55A); push(16'h0004); push(16'h0001); push(16'h0002); push(16'h0003);
        push(16'h0004); push(16'h000A);
        n = 0;
        while (!m_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        rst_n = 1'b0;
        #1;
        check("t7_valid", 32'(m_valid), 32'd0);
        check("t7_get", 32'(ui_dout_get), 32'd0);
        check("t7_cnt", {cnt_ok, cnt_err}, 32'd0);
        check("t7_state", 32'(dbg_state), 32'd0);
        src_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_ready = 1'b1;
        ev0 = ev_seen;
        repeat (20) @(negedge clk);
        #3;
        check("t7_no_pulse", 32'(ev_seen - ev0), 32'd0);
        check("t7_idle_valid", 32'(m_valid), 32'd0);
        push(16'hA55A); push(16'h0001); push(16'h0003); push(16'h0003);
        expect_word(16'h0003, 1'b1); expect_ev(4'b1000);
        wait_idle("t7_after");
        check("t7_after_cnt", {cnt_ok, cnt_err}, {16'd1, 16'd0});

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ft_rx_deframer.md
Name: ft_rx_deframer

Overview:
- Downstream consumer of the FT600/FT601 bridge's read interface, clocked in the system `clk` domain.
- Pops words from the bridge RX FIFO and hunts for a sync word. It then parses a length-prefixed frame, streams the payload out on a valid/ready interface with a last marker, and checks a trailing additive checksum.
- Reports per-frame status pulses and keeps saturating good/error counters for host-link diagnostics.

Parameters:
- BUS_WIDTH, 16, word width; 16 (FT600) or 32 (FT601).
- MAX_LEN, 1024, maximum payload words per frame; legal range 1..65535.
- SYNC_WORD, 16'hA55A, frame start marker; zero-extended to BUS_WIDTH.
- TIMEOUT, 4096, cycles without a pop before a mid-frame abort; must be ≥2.

Ports:
- clk  in  1  system clock; same clock as the bridge's UI side.
- rst_n  in  1  asynchronous active-low reset.
- ui_dout  in  BUS_WIDTH  RX FIFO head word (first-word-fall-through; valid while !ui_dout_empty).
- ui_dout_be  in  BUS_WIDTH/8  byte enables of the head word.
- ui_dout_empty  in  1  1 = no word available.
- ui_dout_get  out  1  pop strobe; combinational.
- m_data  out  BUS_WIDTH  payload word.
- m_be  out  BUS_WIDTH/8  payload byte enables, passed through unchanged.
- m_last  out  1  final payload word of the frame.
- m_valid  out  1  output word valid.
- m_ready  in  1  consumer accepts the word.
- frame_done  out  1  1-cycle pulse when a checksum word is consumed.
- err_csum  out  1  1-cycle pulse with frame_done on checksum mismatch.
- err_len  out  1  1-cycle pulse on an illegal length word.
- err_timeout  out  1  1-cycle pulse on a mid-frame timeout abort.
- cnt_ok  out  16  saturating count of frames with a good checksum.
- cnt_err  out  16  saturating count of err_csum + err_len + err_timeout events.

Behaviour:
- Reset:
  - Asynchronous on rst_n=0: state=HUNT; all pulses 0; m_valid=0, m_last=0; m_data/m_be=0; counters=0; timeout counter=0.
  - ui_dout_get=0 while rst_n=0.
  - Reset mid-frame discards the partial frame with no pulses.
- Frame format, in words:
  - SYNC, then LEN (1..MAX_LEN), then LEN payload words, then CSUM.
  - CSUM = sum of the payload words mod 2^BUS_WIDTH.
- Pop rule:
  - HUNT/LEN/CSUM: ui_dout_get = !ui_dout_empty.
  - PAYLOAD: ui_dout_get = !ui_dout_empty && (!m_valid || m_ready).
  - Each pop processes the head word in the same cycle; state and registers update on the next edge.
- States:
  - HUNT:
    - On pop: word==SYNC_WORD with all be=1 → LEN.
    - Any other word is silently dropped; no error pulse.
  - LEN:
    - On pop: if be not all-ones, or word==0, or word>MAX_LEN → err_len pulse, go to HUNT; the word is consumed.
    - Otherwise: remaining←word, sum←0 → PAYLOAD.
  - PAYLOAD:
    - On pop: m_data←word, m_be←be, m_last←(remaining==1), m_valid←1; sum←sum+word (wraps); remaining←remaining−1.
    - When remaining==1 at the pop → CSUM.
    - Payload be are not checked.
  - CSUM:
    - On pop: frame_done pulse. If word≠sum, also err_csum pulse and cnt_err+1; otherwise cnt_ok+1. Then → HUNT.
    - The CSUM word's be are ignored.
- Output register:
  - m_valid clears on m_valid&&m_ready when no pop occurs in that cycle.
  - A pop in the same cycle as m_ready reloads it; this gives back-to-back throughput of 1 word/cycle.
  - m_data, m_be and m_last hold while m_valid && !m_ready.
  - The output register drains independently of state, so the last word may still be held after entering CSUM/HUNT.
- Timeout:
  - The counter resets on any pop and in HUNT; it increments otherwise in LEN/PAYLOAD/CSUM.
  - Reaching TIMEOUT → err_timeout pulse, cnt_err+1, → HUNT.
  - Payload already emitted is not retracted, and no m_last is generated for the aborted frame.
  - A word still held in the output register completes its handshake normally.
  - Stalls caused by m_ready=0 with the register full still count toward the timeout.
- Counters saturate at 16'hFFFF.
  - If two error events fall in one cycle, cnt_err increments by 1. This cannot occur by construction.
- Latency: one pop to m_valid is 1 cycle.

Test Plan:
- A55A,0003,0001,0002,0003,0006, m_ready=1 → m_data 1,2,3 on consecutive cycles; m_last only with 0003; frame_done=1, err_csum=0; cnt_ok=1.
- Payload FFFF,0002 with CSUM 0001 → sum wraps; frame passes; CSUM 0002 instead → err_csum pulse, cnt_err=1, parser back in HUNT.
- Junk 1234,A55B, then a valid frame → junk dropped with no pulses; the frame is received correctly.
- LEN=0000, and separately LEN=MAX_LEN+1 → err_len pulse each time; the next SYNC is parsed normally.
- Hold m_ready=0 for 5 cycles mid-payload → ui_dout_get=0 while the register is full; no word lost or duplicated; order is preserved after release.
- Stop feeding after 2 of 4 payload words, TIMEOUT=16 → err_timeout exactly 16 cycles after the last pop; state HUNT; a following frame passes.
- Assert rst_n low mid-payload → m_valid=0 immediately; counters 0; no frame_done.
